sdram_access_arbiter: RTL and testbench

- Shares the single SDRAM controller command port among three requesters: m0 instruction fetch, m1 data load/store, m2 debug/DMA loader.
- Picks one request, holds the command until the controller accepts it, and tracks outstanding reads in order so returned read data reaches the requester that issued it.
- Sits between the Reindeer MCU memory ports and the SDRAM controller, in the clk_100MHz domain.

---
 rtl/sdram_access_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_sdram_access_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_access_arbiter
//
// Shares one SDRAM controller command port between three requesters
// (m0 instruction fetch, m1 data load/store, m2 debug/DMA loader).
// One command is in flight at a time: the winner is latched in IDLE, then the
// command is held in ISSUE until the controller drops sd_waitrequest. Every
// accepted read pushes the requester id into an in-order tag FIFO, so that
// returned data can be steered to the requester that issued the read.
//
// Ports
//   clk, sync_reset          clock and synchronous active-high reset
//   m_req/m_rw/m_addr/...    per-requester command inputs, slice i = mi
//   m_ack                    one-cycle accept pulse per requester
//   m_rdata_valid, m_rdata   per-requester read-return strobe, shared data
//   sd_*                     command / return interface to the controller
//   outstanding              reads issued but not yet returned
//   protocol_error           sticky: a return arrived with no read outstanding
// -----------------------------------------------------------------------------
module sdram_access_arbiter #(
  parameter int ADDR_WIDTH      = 22,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIORITY  = 0
) (
  input  logic                               clk,
  input  logic                               sync_reset,
  input  logic [2:0]                         m_req,
  input  logic [2:0]                         m_rw,
  input  logic [3*ADDR_WIDTH-1:0]            m_addr,
  input  logic [3*DATA_WIDTH-1:0]            m_wdata,
  input  logic [5:0]                         m_byteen,
  output logic [2:0]                         m_ack,
  output logic [2:0]                         m_rdata_valid,
  output logic [DATA_WIDTH-1:0]              m_rdata,
  output logic [ADDR_WIDTH-1:0]              sd_addr,
  output logic                               sd_read,
  output logic                               sd_write,
  output logic [DATA_WIDTH-1:0]              sd_wdata,
  output logic [1:0]                         sd_byteen,
  input  logic                               sd_waitrequest,
  input  logic [DATA_WIDTH-1:0]              sd_rdata,
  input  logic                               sd_rdata_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               protocol_error
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            winner_q, winner_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] sd_addr_q, sd_addr_d;
  logic [DATA_WIDTH-1:0] sd_wdata_q, sd_wdata_d;
  logic [1:0]            sd_byteen_q, sd_byteen_d;
  logic                  sd_read_q, sd_read_d;
  logic                  sd_write_q, sd_write_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  protocol_error_q, protocol_error_d;

  // Tag FIFO storage: requester id of each outstanding read, oldest at rd_ptr.
  logic [1:0]            tag_mem [MAX_OUTSTANDING];

  logic [ADDR_WIDTH-1:0] req_addr   [3];
  logic [DATA_WIDTH-1:0] req_wdata  [3];
  logic [1:0]            req_byteen [3];
  logic [2:0]            eligible;
  logic                  not_full;
  logic                  found;
  logic [1:0]            sel;
  logic [1:0]            cand;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Request unpacking and eligibility. Writes never consume a tag, so only
  // reads are held off when the tag FIFO is full.
  // ---------------------------------------------------------------------------
  assign not_full = (count_q < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_addr[i]   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      req_wdata[i]  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      req_byteen[i] = m_byteen[i*2 +: 2];
      eligible[i]   = m_req[i] & (m_rw[i] | not_full);
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection: first eligible requester in search order. Round-robin
  // starts just after the last accepted requester; fixed priority is 0,1,2.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    found = 1'b0;
    sel   = 2'd0;
    cand  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (FIXED_PRIORITY != 0) begin
        cand = 2'(k);
      end else begin
        cand = 2'((int'(last_grant_q) + k + 1) % 3);
      end
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM: latch the winner in IDLE, hold it in ISSUE until accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    sd_addr_d    = sd_addr_q;
    sd_wdata_d   = sd_wdata_q;
    sd_byteen_d  = sd_byteen_q;
    sd_read_d    = sd_read_q;
    sd_write_d   = sd_write_q;
    push         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          winner_d    = sel;
          sd_addr_d   = req_addr[sel];
          sd_wdata_d  = req_wdata[sel];
          sd_byteen_d = req_byteen[sel];
          sd_read_d   = ~m_rw[sel];
          sd_write_d  = m_rw[sel];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!sd_waitrequest) begin
          push         = sd_read_q;
          last_grant_d = winner_q;
          sd_read_d    = 1'b0;
          sd_write_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO bookkeeping. A return with nothing outstanding is not popped
  // (no underflow) and instead raises the sticky error flag.
  // ---------------------------------------------------------------------------
  assign pop = sd_rdata_valid && (count_q != '0);

  always_comb begin
    wr_ptr_d         = wr_ptr_q + PTR_W'(push);
    rd_ptr_d         = rd_ptr_q + PTR_W'(pop);
    count_d          = count_q + CNT_W'(push) - CNT_W'(pop);
    protocol_error_d = protocol_error_q | (sd_rdata_valid && (count_q == '0));
  end

  // Accept and return strobes are combinational; they are suppressed while
  // reset is asserted so a command dropped by reset is never acknowledged.
  always_comb begin
    m_ack         = 3'b000;
    m_rdata_valid = 3'b000;
    if ((state_q == ISSUE) && !sd_waitrequest && !sync_reset) begin
      m_ack[winner_q] = 1'b1;
    end
    if (pop && !sync_reset) begin
      m_rdata_valid[tag_mem[rd_ptr_q]] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (sync_reset) begin
      state_q          <= IDLE;
      winner_q         <= 2'd0;
      last_grant_q     <= 2'd2;
      sd_addr_q        <= '0;
      sd_wdata_q       <= '0;
      sd_byteen_q      <= '0;
      sd_read_q        <= 1'b0;
      sd_write_q       <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      winner_q         <= winner_d;
      last_grant_q     <= last_grant_d;
      sd_addr_q        <= sd_addr_d;
      sd_wdata_q       <= sd_wdata_d;
      sd_byteen_q      <= sd_byteen_d;
      sd_read_q        <= sd_read_d;
      sd_write_q       <= sd_write_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // NOTE: the tag storage has no reset; an entry is only read after it has
  // been written, and the pointers/count that qualify it are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= winner_q;
    end
  end

  assign sd_addr        = sd_addr_q;
  assign sd_wdata       = sd_wdata_q;
  assign sd_byteen      = sd_byteen_q;
  assign sd_read        = sd_read_q;
  assign sd_write       = sd_write_q;
  assign m_rdata        = sd_rdata;
  assign outstanding    = count_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for sdram_access_arbiter. A transaction-level reference model
// (pending command record, tag queue, last grant) predicts every output each
// cycle; directed scenario tasks add explicit checks on top.
// -----------------------------------------------------------------------------
module tb_sdram_access_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            sync_reset;
  logic [2:0]      m_req;
  logic [2:0]      m_rw;
  logic [3*AW-1:0] m_addr;
  logic [3*DW-1:0] m_wdata;
  logic [5:0]      m_byteen;
  logic            sd_waitrequest;
  logic [DW-1:0]   sd_rdata;
  logic            sd_rdata_valid;

  logic [2:0]      m_ack, m_rdata_valid;
  logic [DW-1:0]   m_rdata;
  logic [AW-1:0]   sd_addr;
  logic            sd_read, sd_write;
  logic [DW-1:0]   sd_wdata;
  logic [1:0]      sd_byteen;
  logic [2:0]      outstanding;
  logic            protocol_error;

  logic [2:0]      m_ack_fp, m_rdata_valid_fp;
  logic [DW-1:0]   m_rdata_fp;
  logic [AW-1:0]   sd_addr_fp;
  logic            sd_read_fp, sd_write_fp;
  logic [DW-1:0]   sd_wdata_fp;
  logic [1:0]      sd_byteen_fp;
  logic [2:0]      outstanding_fp;
  logic            protocol_error_fp;

  always #5 clk = ~clk;

  sdram_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(0)
  ) u_dut (
    .clk(clk), .sync_reset(sync_reset),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_ack(m_ack), .m_rdata_valid(m_rdata_valid), .m_rdata(m_rdata),
    .sd_addr(sd_addr), .sd_read(sd_read), .sd_write(sd_write), .sd_wdata(sd_wdata),
    .sd_byteen(sd_byteen), .sd_waitrequest(sd_waitrequest), .sd_rdata(sd_rdata),
    .sd_rdata_valid(sd_rdata_valid), .outstanding(outstanding), .protocol_error(protocol_error)
  );

  sdram_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .FIXED_PRIORITY(1)
  ) u_dut_fp (
    .clk(clk), .sync_reset(sync_reset),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_ack(m_ack_fp), .m_rdata_valid(m_rdata_valid_fp), .m_rdata(m_rdata_fp),
    .sd_addr(sd_addr_fp), .sd_read(sd_read_fp), .sd_write(sd_write_fp), .sd_wdata(sd_wdata_fp),
    .sd_byteen(sd_byteen_fp), .sd_waitrequest(sd_waitrequest), .sd_rdata(sd_rdata),
    .sd_rdata_valid(sd_rdata_valid), .outstanding(outstanding_fp), .protocol_error(protocol_error_fp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit            pend_valid;
  int            pend_id;
  bit            pend_rw;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;
  logic [1:0]    pend_be;
  int            lastg;
  int            tagq[$];
  bit            perr;

  // Snapshot of DUT outputs taken in the most recent step
  logic [2:0]    snap_ack, snap_rv, snap_ack_fp;
  logic          snap_rd, snap_wr;
  logic [AW-1:0] snap_addr;
  logic [DW-1:0] snap_wdata;
  logic [1:0]    snap_be;

  // One clock cycle: compare DUT outputs with the model's prediction for the
  // inputs currently applied, advance the model, wait for the next falling
  // edge, then drop the requests that were accepted.
  task automatic step();
    logic [2:0] e_ack, e_rv;
    logic       e_rd, e_wr;
    int         sz, cand;
    bit         got;
    #1;
    e_rd  = pend_valid && !pend_rw;
    e_wr  = pend_valid && pend_rw;
    e_ack = 3'b000;
    e_rv  = 3'b000;
    if (pend_valid && !sd_waitrequest && !sync_reset) e_ack[pend_id] = 1'b1;
    if (sd_rdata_valid && tagq.size() > 0 && !sync_reset) e_rv[tagq[0]] = 1'b1;

    snap_ack = m_ack; snap_rv = m_rdata_valid; snap_ack_fp = m_ack_fp;
    snap_rd = sd_read; snap_wr = sd_write;
    snap_addr = sd_addr; snap_wdata = sd_wdata; snap_be = sd_byteen;

    n_cmp++; if (sd_read !== e_rd) begin n_bad++; $display("FAIL sd_read @%0t: got %b want %b", $time, sd_read, e_rd); end
    n_cmp++; if (sd_write !== e_wr) begin n_bad++; $display("FAIL sd_write @%0t: got %b want %b", $time, sd_write, e_wr); end
    n_cmp++; if (m_ack !== e_ack) begin n_bad++; $display("FAIL m_ack @%0t: got %b want %b", $time, m_ack, e_ack); end
    n_cmp++; if (m_rdata_valid !== e_rv) begin n_bad++; $display("FAIL m_rdata_valid @%0t: got %b want %b", $time, m_rdata_valid, e_rv); end
    n_cmp++; if (outstanding !== 3'(tagq.size())) begin n_bad++; $display("FAIL outstanding @%0t: got %0d want %0d", $time, outstanding, tagq.size()); end
    n_cmp++; if (protocol_error !== perr) begin n_bad++; $display("FAIL protocol_error @%0t: got %b want %b", $time, protocol_error, perr); end
    n_cmp++; if (m_rdata !== sd_rdata) begin n_bad++; $display("FAIL m_rdata @%0t: got %h want %h", $time, m_rdata, sd_rdata); end
    if (pend_valid) begin
      n_cmp++; if (sd_addr !== pend_addr) begin n_bad++; $display("FAIL sd_addr @%0t: got %h want %h", $time, sd_addr, pend_addr); end
      n_cmp++; if (sd_wdata !== pend_wdata) begin n_bad++; $display("FAIL sd_wdata @%0t: got %h want %h", $time, sd_wdata, pend_wdata); end
      n_cmp++; if (sd_byteen !== pend_be) begin n_bad++; $display("FAIL sd_byteen @%0t: got %b want %b", $time, sd_byteen, pend_be); end
    end

    sz = tagq.size();
    if (sync_reset) begin
      pend_valid = 0; lastg = 2; tagq.delete(); perr = 0;
    end else begin
      if (!pend_valid) begin
        got = 0;
        for (int k = 1; k <= 3; k++) begin
          cand = (lastg + k) % 3;
          if (!got && m_req[cand] && (m_rw[cand] || sz < MO)) begin
            got = 1; pend_valid = 1; pend_id = cand; pend_rw = m_rw[cand];
            pend_addr = m_addr[cand*AW +: AW]; pend_wdata = m_wdata[cand*DW +: DW];
            pend_be = m_byteen[cand*2 +: 2];
          end
        end
      end else if (!sd_waitrequest) begin
        if (!pend_rw) tagq.push_back(pend_id);
        lastg = pend_id;
        pend_valid = 0;
      end
      if (sd_rdata_valid) begin
        if (sz > 0) void'(tagq.pop_front());
        else perr = 1;
      end
    end
    @(negedge clk);
    m_req = m_req & ~e_ack;
  endtask

  task automatic apply_reset();
    m_req = 3'b000; sd_rdata_valid = 0; sd_waitrequest = 0; sync_reset = 1;
    step(); step();
    sync_reset = 0;
  endtask

  task automatic test_reset();
    m_req = 3'($urandom); m_rw = 3'($urandom); sd_waitrequest = 1'($urandom);
    sync_reset = 1;
    for (int c = 0; c < 3; c++) step();
    n_cmp++; if ({sd_read, sd_write, m_ack} !== 5'b0) begin n_bad++; $display("FAIL reset_cmd: got %b want 0", {sd_read, sd_write, m_ack}); end
    n_cmp++; if (sd_addr !== '0 || sd_wdata !== '0 || sd_byteen !== '0) begin n_bad++; $display("FAIL reset_data: got %h/%h/%b want 0", sd_addr, sd_wdata, sd_byteen); end
    n_cmp++; if (outstanding !== 3'd0 || protocol_error !== 1'b0) begin n_bad++; $display("FAIL reset_status: got %0d/%b want 0/0", outstanding, protocol_error); end
    sync_reset = 0;
    m_req = 3'b000;
  endtask

  task automatic test_single_read();
    apply_reset();
    m_rw = 3'b000; m_addr[1*AW +: AW] = 22'h00123; m_req = 3'b010;
    step();
    n_cmp++; if (sd_read !== 1'b1 || sd_addr !== 22'h00123) begin n_bad++; $display("FAIL single_issue: got rd=%b addr=%h want 1/00123", sd_read, sd_addr); end
    step();
    n_cmp++; if (snap_ack !== 3'b010) begin n_bad++; $display("FAIL single_ack: got %b want 010", snap_ack); end
    n_cmp++; if (sd_read !== 1'b0 || outstanding !== 3'd1) begin n_bad++; $display("FAIL single_after: got rd=%b out=%0d want 0/1", sd_read, outstanding); end
    step(); step();
    sd_rdata = 16'hBEEF; sd_rdata_valid = 1;
    step();
    sd_rdata_valid = 0;
    n_cmp++; if (snap_rv !== 3'b010) begin n_bad++; $display("FAIL single_return: got %b want 010", snap_rv); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL single_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    apply_reset();
    m_rw = 3'b000;
    for (int c = 0; c < 14; c++) begin
      m_req = 3'b111;
      sd_rdata_valid = (tagq.size() > 0);
      sd_rdata = 16'($urandom);
      step();
      for (int i = 0; i < 3; i++) if (snap_ack[i]) grants.push_back(i);
      n_cmp++;
      if (snap_ack_fp !== ((snap_ack != 3'b000) ? 3'b001 : 3'b000)) begin
        n_bad++; $display("FAIL fixed_prio_ack @%0t: got %b", $time, snap_ack_fp);
      end
    end
    sd_rdata_valid = 0; m_req = 3'b000;
    n_cmp++;
    if (grants.size() < 6) begin
      n_bad++; $display("FAIL rr_count: got %0d grants want >=6", grants.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (grants[i] !== exp_order[i]) begin n_bad++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", i, grants[i], exp_order[i]); end
      end
    end
  endtask

  task automatic test_stall();
    int stable, acks, ack_c;
    apply_reset();
    m_rw = 3'b100; m_addr[2*AW +: AW] = 22'h3FFFFF; m_wdata[2*DW +: DW] = 16'h1234;
    m_byteen[5:4] = 2'b01; m_req = 3'b100;
    step();
    sd_waitrequest = 1; stable = 0; acks = 0; ack_c = -1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin m_rw[0] = 0; m_addr[0 +: AW] = 22'($urandom); m_req[0] = 1; end
      if (c == 5) sd_waitrequest = 0;
      step();
      if (snap_wr && snap_addr == 22'h3FFFFF && snap_wdata == 16'h1234 && snap_be == 2'b01) stable++;
      if (snap_ack[2]) begin acks++; ack_c = c; end
    end
    n_cmp++; if (stable !== 6) begin n_bad++; $display("FAIL stall_stable: got %0d cycles want 6", stable); end
    n_cmp++; if (acks !== 1 || ack_c !== 5) begin n_bad++; $display("FAIL stall_ack: got %0d pulses at %0d want 1 at 5", acks, ack_c); end
    for (int c = 0; c < 4; c++) step();
    m_req = 3'b000;
  endtask

  task automatic test_fifo_full();
    int ids[4] = '{0, 1, 2, 0};
    int rets[4] = '{1, 2, 0, 0};
    int rd_seen, ack1;
    bit got;
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      m_rw[ids[n]] = 0; m_addr[ids[n]*AW +: AW] = 22'($urandom); m_req[ids[n]] = 1;
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin step(); got = snap_ack[ids[n]]; end
      n_cmp++; if (!got) begin n_bad++; $display("FAIL full_fill: m%0d read never acked", ids[n]); end
    end
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", outstanding); end
    m_rw[0] = 0; m_req[0] = 1; m_rw[1] = 1; m_wdata[DW +: DW] = 16'($urandom); m_req[1] = 1;
    rd_seen = 0; ack1 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (snap_rd) rd_seen++;
      if (snap_ack[1]) ack1++;
    end
    n_cmp++; if (rd_seen !== 0) begin n_bad++; $display("FAIL full_block: got %0d read cycles want 0", rd_seen); end
    n_cmp++; if (ack1 !== 1) begin n_bad++; $display("FAIL full_write: got %0d acks want 1", ack1); end
    sd_rdata_valid = 1; sd_rdata = 16'($urandom);
    step();
    sd_rdata_valid = 0;
    n_cmp++; if (snap_rv !== 3'b001) begin n_bad++; $display("FAIL full_ret0: got %b want 001", snap_rv); end
    got = 0;
    for (int w = 0; w < 6 && !got; w++) begin step(); got = snap_ack[0]; end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL full_unblock: m0 read not acked after return"); end
    for (int n = 0; n < 4; n++) begin
      sd_rdata_valid = 1; sd_rdata = 16'($urandom);
      step();
      sd_rdata_valid = 0;
      n_cmp++; if (snap_rv[rets[n]] !== 1'b1) begin n_bad++; $display("FAIL full_ret%0d: got %b want m%0d", n + 1, snap_rv, rets[n]); end
      step();
    end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL full_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_error_reset();
    bit got;
    apply_reset();
    sd_rdata_valid = 1;
    step();
    sd_rdata_valid = 0;
    n_cmp++; if (snap_rv !== 3'b000) begin n_bad++; $display("FAIL err_valid: got %b want 000", snap_rv); end
    n_cmp++; if (protocol_error !== 1'b1 || outstanding !== 3'd0) begin n_bad++; $display("FAIL err_flag: got %b/%0d want 1/0", protocol_error, outstanding); end
    step(); step();
    m_rw = 3'b000; m_addr[AW +: AW] = 22'($urandom); m_req = 3'b010;
    step();
    sd_waitrequest = 1;
    step();
    sync_reset = 1;
    step();
    sync_reset = 0;
    n_cmp++; if (snap_ack !== 3'b000) begin n_bad++; $display("FAIL err_noack: got %b want 000", snap_ack); end
    n_cmp++; if ({sd_read, sd_write, protocol_error, outstanding} !== 6'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", {sd_read, sd_write, protocol_error, outstanding}); end
    sd_waitrequest = 0;
    got = 0;
    for (int w = 0; w < 6 && !got; w++) begin step(); got = snap_ack[1]; end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL err_reissue: m1 read not reissued after reset"); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_req[i] && ($urandom % 3 == 0)) begin
          m_rw[i] = 1'($urandom); m_addr[i*AW +: AW] = 22'($urandom);
          m_wdata[i*DW +: DW] = 16'($urandom); m_byteen[i*2 +: 2] = 2'($urandom);
          m_req[i] = 1;
        end
      end
      sd_waitrequest = ($urandom % 4 == 0);
      sd_rdata_valid = (tagq.size() > 0) ? 1'($urandom) : ($urandom % 16 == 0);
      sd_rdata = 16'($urandom);
      sync_reset = (c % 150 == 149);
      step();
    end
    sync_reset = 0; sd_rdata_valid = 0; m_req = 3'b000;
  endtask

  initial begin
    lastg = 2; pend_valid = 0; perr = 0;
    sync_reset = 1; m_req = 0; m_rw = 0; m_addr = '0; m_wdata = '0; m_byteen = '0;
    sd_waitrequest = 0; sd_rdata = '0; sd_rdata_valid = 0;
    @(negedge clk); @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_fifo_full();
    test_error_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

endmodule
